// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, position widths, colour type and direction encoding
package vga_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int X_W = $clog2(DEF_H_ACTIVE);
    localparam int Y_W = $clog2(DEF_V_ACTIVE);
    typedef logic [2:0] colour_t;
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;
    // colour index cycles 1..7 so the box never takes the all-black colour
    function automatic colour_t next_colour(input colour_t c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction
endpackage

// File: rtl/box_axis_mover.sv
// box_axis_mover: one axis of the bouncing box; steps on each enabled tick and reflects at 0 and LIM
module box_axis_mover
    import vga_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int LIM   = 608,
    parameter int START = 304
) (
    input  logic             i_Clk,
    input  logic             rst,
    input  logic [2:0]       i_step,
    input  logic             i_enable,
    input  logic             i_tick,
    output logic [WIDTH-1:0] o_pos,
    output logic             o_dir,
    output logic             o_bounce
);
    logic [WIDTH:0]   w_pos;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_sum;
    logic             w_hit_hi;
    logic             w_hit_lo;
    logic             w_move;
    logic [WIDTH-1:0] w_next_pos;
    logic             w_next_dir;

    // one extra bit so pos+step cannot wrap before the limit compare
    always_comb begin
        w_pos      = {1'b0, o_pos};
        w_step     = (WIDTH+1)'(i_step);
        w_sum      = w_pos + w_step;
        w_hit_hi   = (o_dir == DIR_POS) && (w_sum >= (WIDTH+1)'(LIM));
        w_hit_lo   = (o_dir == DIR_NEG) && (w_pos <= w_step);
        w_move     = i_tick && i_enable;
        o_bounce   = w_move && (w_hit_hi || w_hit_lo);
        w_next_pos = w_hit_hi ? WIDTH'(LIM) : w_hit_lo ? '0 :
                     (o_dir == DIR_POS) ? w_sum[WIDTH-1:0] : o_pos - WIDTH'(i_step);
        w_next_dir = w_hit_hi ? DIR_NEG : w_hit_lo ? DIR_POS : o_dir;
    end

    always_ff @(posedge i_Clk) begin
        if (rst) begin
            o_pos <= WIDTH'(START);
            o_dir <= DIR_POS;
        end else if (w_move) begin
            o_pos <= w_next_pos;
            o_dir <= w_next_dir;
        end
    end
endmodule

// File: rtl/vga_bounce_box.sv
// vga_bounce_box: pixel source drawing a solid square that moves once per frame and bounces off the edges
module vga_bounce_box
    import vga_pkg::*;
#(
    parameter int         H_ACTIVE = DEF_H_ACTIVE,
    parameter int         V_ACTIVE = DEF_V_ACTIVE,
    parameter int         BOX_SIZE = 32,
    parameter logic [2:0] BG_R     = 3'd0,
    parameter logic [2:0] BG_G     = 3'd0,
    parameter logic [2:0] BG_B     = 3'd1
) (
    input  logic                        i_Clk,
    input  logic                        rst,
    input  logic [$clog2(H_ACTIVE)-1:0] x_pos,
    input  logic [$clog2(V_ACTIVE)-1:0] y_pos,
    input  logic                        valid_pos,
    input  logic [1:0]                  i_speed,
    input  logic                        i_pause,
    output logic [2:0]                  r_px,
    output logic [2:0]                  g_px,
    output logic [2:0]                  b_px,
    output logic                        o_frame_tick
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    logic [XW-1:0] w_box_x;
    logic [YW-1:0] w_box_y;
    logic          w_dir_x;
    logic          w_dir_y;
    logic          w_bounce_x;
    logic          w_bounce_y;
    logic          w_unused_dirs;
    logic          w_tick;
    logic [2:0]    w_step;
    logic          w_inside;
    colour_t       r_colour;

    assign w_tick        = valid_pos && (x_pos == XW'(H_ACTIVE-1)) && (y_pos == YW'(V_ACTIVE-1));
    assign w_step        = {1'b0, i_speed} + 3'd1;
    assign w_unused_dirs = w_dir_x ^ w_dir_y;
    assign w_inside      = ({1'b0, x_pos} >= {1'b0, w_box_x}) &&
                           ({1'b0, x_pos} <  {1'b0, w_box_x} + (XW+1)'(BOX_SIZE)) &&
                           ({1'b0, y_pos} >= {1'b0, w_box_y}) &&
                           ({1'b0, y_pos} <  {1'b0, w_box_y} + (YW+1)'(BOX_SIZE));

    box_axis_mover #(.WIDTH(XW), .LIM(H_ACTIVE-BOX_SIZE), .START((H_ACTIVE-BOX_SIZE)/2)) u_x (
        .i_Clk(i_Clk), .rst(rst), .i_step(w_step), .i_enable(!i_pause), .i_tick(w_tick),
        .o_pos(w_box_x), .o_dir(w_dir_x), .o_bounce(w_bounce_x)
    );

    box_axis_mover #(.WIDTH(YW), .LIM(V_ACTIVE-BOX_SIZE), .START((V_ACTIVE-BOX_SIZE)/2)) u_y (
        .i_Clk(i_Clk), .rst(rst), .i_step(w_step), .i_enable(!i_pause), .i_tick(w_tick),
        .o_pos(w_box_y), .o_dir(w_dir_y), .o_bounce(w_bounce_y)
    );

    // a corner hit bounces both axes in one frame but advances the colour only once
    always_ff @(posedge i_Clk) begin
        if (rst) begin
            r_colour     <= 3'd7;
            o_frame_tick <= 1'b0;
            r_px         <= '0;
            g_px         <= '0;
            b_px         <= '0;
        end else begin
            o_frame_tick <= w_tick;
            if (w_bounce_x || w_bounce_y) r_colour <= next_colour(r_colour);
            r_px <= !valid_pos ? 3'd0 : w_inside ? {3{r_colour[0]}} : BG_R;
            g_px <= !valid_pos ? 3'd0 : w_inside ? {3{r_colour[1]}} : BG_G;
            b_px <= !valid_pos ? 3'd0 : w_inside ? {3{r_colour[2]}} : BG_B;
        end
    end
endmodule

// File: tb/tb_vga_bounce_box.sv
// tb_vga_bounce_box: directed checks of pixel path, frame tick, bounce, colour stepping, pause and reset
module tb_vga_bounce_box;
    logic       i_Clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x_pos = '0;
    logic [8:0] y_pos = '0;
    logic       valid_pos = 1'b0;
    logic [1:0] i_speed = 2'd0;
    logic       i_pause = 1'b0;
    logic [2:0] r_px, g_px, b_px;
    logic       o_frame_tick;
    logic [5:0] s_x = '0;
    logic [5:0] s_y = '0;
    logic       s_valid = 1'b0;
    logic [1:0] s_speed = 2'd3;
    logic       s_pause = 1'b0;
    logic [2:0] s_r, s_g, s_b;
    logic       s_tick;
    int         n_checks = 0;
    int         n_fail = 0;

    localparam logic [8:0] BG = 9'b000_000_001;

    vga_bounce_box dut (
        .i_Clk(i_Clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .valid_pos(valid_pos),
        .i_speed(i_speed), .i_pause(i_pause), .r_px(r_px), .g_px(g_px), .b_px(b_px),
        .o_frame_tick(o_frame_tick)
    );

    // square screen: both axes start equal and therefore hit their corner in the same frame
    vga_bounce_box #(.H_ACTIVE(64), .V_ACTIVE(64), .BOX_SIZE(8)) dut_sq (
        .i_Clk(i_Clk), .rst(rst), .x_pos(s_x), .y_pos(s_y), .valid_pos(s_valid),
        .i_speed(s_speed), .i_pause(s_pause), .r_px(s_r), .g_px(s_g), .b_px(s_b),
        .o_frame_tick(s_tick)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [8:0] box_rgb(input logic [2:0] c);
        return {{3{c[0]}}, {3{c[1]}}, {3{c[2]}}};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic probe(input int x, input int y, input logic v, output logic [8:0] rgb);
        x_pos = 10'(x);
        y_pos = 9'(y);
        valid_pos = v;
        @(posedge i_Clk);
        #1;
        rgb = {r_px, g_px, b_px};
        valid_pos = 1'b0;
    endtask

    task automatic frame(output logic t_on, output logic t_after);
        x_pos = 10'd639;
        y_pos = 9'd479;
        valid_pos = 1'b1;
        @(posedge i_Clk);
        #1;
        t_on = o_frame_tick;
        valid_pos = 1'b0;
        x_pos = '0;
        y_pos = '0;
        @(posedge i_Clk);
        #1;
        t_after = o_frame_tick;
    endtask

    task automatic run_frames(input int n, output int ticks, output int extra);
        logic a, b;
        ticks = 0;
        extra = 0;
        for (int i = 0; i < n; i++) begin
            frame(a, b);
            ticks += int'(a);
            extra += int'(b);
        end
    endtask

    task automatic chk_box(input string tag, input int bx, input int by, input logic [2:0] c);
        logic [8:0] rgb;
        probe(bx, by, 1'b1, rgb);
        check({tag, "_corner"}, 32'(rgb), 32'(box_rgb(c)));
        probe(bx + 31, by + 31, 1'b1, rgb);
        check({tag, "_far"}, 32'(rgb), 32'(box_rgb(c)));
        if (bx > 0) begin
            probe(bx - 1, by, 1'b1, rgb);
            check({tag, "_left"}, 32'(rgb), 32'(BG));
        end
        if (by > 0) begin
            probe(bx, by - 1, 1'b1, rgb);
            check({tag, "_above"}, 32'(rgb), 32'(BG));
        end
        if (bx + 32 < 640) begin
            probe(bx + 32, by, 1'b1, rgb);
            check({tag, "_right"}, 32'(rgb), 32'(BG));
        end
        if (by + 32 < 480) begin
            probe(bx, by + 32, 1'b1, rgb);
            check({tag, "_below"}, 32'(rgb), 32'(BG));
        end
    endtask

    task automatic sq_probe(input int x, input int y, output logic [8:0] rgb);
        s_x = 6'(x);
        s_y = 6'(y);
        s_valid = 1'b1;
        @(posedge i_Clk);
        #1;
        rgb = {s_r, s_g, s_b};
        s_valid = 1'b0;
    endtask

    initial begin
        logic [8:0] rgb;
        logic t_on, t_after;
        int ticks, extra;
        repeat (2) @(posedge i_Clk);
        #1;
        check("reset_rgb", 32'({r_px, g_px, b_px}), 32'd0);
        check("reset_tick", 32'(o_frame_tick), 32'd0);
        rst = 1'b0;

        probe(304, 224, 1'b1, rgb); check("px_304_224", 32'(rgb), 32'h1FF);
        probe(303, 224, 1'b1, rgb); check("px_303_224", 32'(rgb), 32'(BG));
        probe(335, 255, 1'b1, rgb); check("px_335_255", 32'(rgb), 32'h1FF);
        probe(336, 224, 1'b1, rgb); check("px_336_224", 32'(rgb), 32'(BG));
        probe(304, 223, 1'b1, rgb); check("px_304_223", 32'(rgb), 32'(BG));
        probe(310, 230, 1'b0, rgb); check("px_invalid", 32'(rgb), 32'd0);

        i_speed = 2'd3;
        frame(t_on, t_after);
        check("tick_on", 32'(t_on), 32'd1);
        check("tick_off", 32'(t_after), 32'd0);
        chk_box("f1", 308, 228, 3'd7);

        run_frames(55, ticks, extra);
        check("f56_ticks", 32'(ticks), 32'd55);
        chk_box("f56", 528, 448, 3'd1);

        run_frames(20, ticks, extra);
        check("f76_extra", 32'(extra), 32'd0);
        chk_box("f76", 608, 368, 3'd2);

        i_pause = 1'b1;
        i_speed = 2'd0;
        run_frames(10, ticks, extra);
        check("pause_ticks", 32'(ticks), 32'd10);
        check("pause_extra", 32'(extra), 32'd0);
        chk_box("pause", 608, 368, 3'd2);

        i_pause = 1'b0;
        run_frames(1, ticks, extra);
        chk_box("slow", 607, 367, 3'd2);

        x_pos = 10'd610;
        y_pos = 9'd370;
        valid_pos = 1'b1;
        rst = 1'b1;
        @(posedge i_Clk);
        #1;
        check("midrst_rgb", 32'({r_px, g_px, b_px}), 32'd0);
        rst = 1'b0;
        valid_pos = 1'b0;
        chk_box("after_rst", 304, 224, 3'd7);

        for (int i = 0; i < 7; i++) begin
            s_x = 6'd63;
            s_y = 6'd63;
            s_valid = 1'b1;
            @(posedge i_Clk);
            #1;
            s_valid = 1'b0;
        end
        sq_probe(56, 56, rgb); check("sq_corner", 32'(rgb), 32'(box_rgb(3'd1)));
        sq_probe(63, 62, rgb); check("sq_far", 32'(rgb), 32'(box_rgb(3'd1)));
        sq_probe(55, 56, rgb); check("sq_left", 32'(rgb), 32'(BG));
        sq_probe(56, 55, rgb); check("sq_above", 32'(rgb), 32'(BG));
        s_x = 6'd63;
        s_y = 6'd63;
        s_valid = 1'b1;
        @(posedge i_Clk);
        #1;
        s_valid = 1'b0;
        check("sq_tick", 32'(s_tick), 32'd1);
        sq_probe(52, 52, rgb); check("sq_back", 32'(rgb), 32'(box_rgb(3'd1)));
        sq_probe(60, 52, rgb); check("sq_right", 32'(rgb), 32'(BG));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
